// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction buffer between fetch and decode.
// Holds {instr, pc} entries while decode stalls, optionally bypasses an
// empty queue in the same cycle, raises stop_fetch early enough for the
// in-flight fetches to land, and keeps a sticky overflow flag.
module fetch_queue #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 16,
  parameter int DEPTH  = 4,
  parameter int SLACK  = 2,
  parameter int BYPASS = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_instr,
  input  logic [PC_W-1:0]            in_pc,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_instr,
  output logic [PC_W-1:0]            out_pc,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       stop_fetch,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = DATA_W + PC_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] STOP_CNT = CNT_W'(DEPTH - SLACK);

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             empty, push, pop, bypass_fire, mem_we;
  logic [ENT_W-1:0] head;

  // Handshakes and head selection; in_ready deliberately ignores out_ready.
  always_comb begin
    empty       = (count_q == '0);
    in_ready    = !reset && (count_q != FULL_CNT);
    out_valid   = !reset && !flush && (!empty || ((BYPASS != 0) && in_valid));
    push        = in_valid && in_ready;
    pop         = out_valid && out_ready;
    bypass_fire = empty && push && pop;
    head        = empty ? {in_instr, in_pc} : mem_q[rd_ptr_q];
  end

  assign out_instr  = head[ENT_W-1:PC_W];
  assign out_pc     = head[PC_W-1:0];
  assign count      = count_q;
  assign stop_fetch = (count_q >= STOP_CNT);
  assign overflow   = overflow_q;

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    mem_we     = 1'b0;
    overflow_d = overflow_q | (in_valid & !in_ready & !flush);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (!bypass_fire) begin
      if (push) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage; never reset, only read while the slot holds live data.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= {in_instr, in_pc};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: random traffic into two fetch_queue configurations
// (DEPTH=4/SLACK=2/bypass and DEPTH=8/SLACK=3/no bypass), each compared
// every cycle against a queue-based reference model.
module tb_fetch_queue;

  localparam int NUM_CYCLES = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        inValid;
  logic [15:0] inInstr;
  logic [15:0] inPc;
  logic        outReady;

  logic        inReady0, outValid0, stop0, ovfFlag0;
  logic [15:0] outInstr0, outPc0;
  logic [2:0]  count0;
  logic        inReady1, outValid1, stop1, ovfFlag1;
  logic [15:0] outInstr1, outPc1;
  logic [3:0]  count1;

  int tests = 0;
  int fails = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  bit          expOvf0, expOvf1;

  always #5 clk = ~clk;

  fetch_queue #(.DATA_W(16), .PC_W(16), .DEPTH(4), .SLACK(2), .BYPASS(1)) u0 (
    .clk(clk), .reset(rst), .flush(flush),
    .in_valid(inValid), .in_instr(inInstr), .in_pc(inPc), .in_ready(inReady0),
    .out_valid(outValid0), .out_instr(outInstr0), .out_pc(outPc0),
    .out_ready(outReady), .count(count0), .stop_fetch(stop0), .overflow(ovfFlag0)
  );

  fetch_queue #(.DATA_W(16), .PC_W(16), .DEPTH(8), .SLACK(3), .BYPASS(0)) u1 (
    .clk(clk), .reset(rst), .flush(flush),
    .in_valid(inValid), .in_instr(inInstr), .in_pc(inPc), .in_ready(inReady1),
    .out_valid(outValid1), .out_instr(outInstr1), .out_pc(outPc1),
    .out_ready(outReady), .count(count1), .stop_fetch(stop1), .overflow(ovfFlag1)
  );

  // Count one comparison and report it when it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Random inputs for one cycle; out_ready alternates between stall-heavy
  // and drain-heavy phases so the queues regularly reach full and empty.
  task automatic applyStimulus(input int cycle);
    int readyPct;
    readyPct = (((cycle / 60) % 2) == 0) ? 15 : 85;
    rst      = (cycle < 2) || ($urandom_range(0, 199) < 3);
    flush    = ($urandom_range(0, 99) < 4);
    inValid  = ($urandom_range(0, 99) < 75);
    outReady = ($urandom_range(0, 99) < readyPct);
    inInstr  = 16'($urandom);
    inPc     = 16'($urandom);
  endtask

  // Expected outputs of one configuration from its model occupancy and the
  // current inputs; returns what the queue will do at the coming edge.
  task automatic checkUnit(input string tag, input int size, input int depth,
                           input int slack, input bit byp, input logic [31:0] head,
                           input bit expOvf, input logic obsReady, input logic obsValid,
                           input logic [31:0] obsData, input logic [31:0] obsCount,
                           input logic obsStop, input logic obsOvf,
                           output bit push, output bit pop, output bit ovfSet);
    bit expReady, expValid;
    expReady = !rst && (size != depth);
    expValid = !rst && !flush && ((size != 0) || (byp && inValid));
    push     = inValid && expReady;
    pop      = expValid && outReady;
    ovfSet   = !rst && !flush && inValid && !expReady;
    checkOutput({tag, ".count"}, obsCount, size);
    checkOutput({tag, ".in_ready"}, {31'b0, obsReady}, {31'b0, expReady});
    checkOutput({tag, ".out_valid"}, {31'b0, obsValid}, {31'b0, expValid});
    checkOutput({tag, ".stop_fetch"}, {31'b0, obsStop}, {31'b0, size >= depth - slack});
    checkOutput({tag, ".overflow"}, {31'b0, obsOvf}, {31'b0, expOvf});
    if (expValid) begin
      checkOutput({tag, ".data"}, obsData, (size != 0) ? head : {inInstr, inPc});
    end
  endtask

  initial begin
    bit push0, pop0, set0, push1, pop1, set1;
    int sz;
    logic [31:0] head0, head1;
    rst = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
    inInstr = '0; inPc = '0;
    expOvf0 = 1'b0; expOvf1 = 1'b0;
    @(negedge clk);
    for (int cycle = 0; cycle < NUM_CYCLES; cycle++) begin
      applyStimulus(cycle);
      #2;
      head0 = (q0.size() != 0) ? q0[0] : 32'h0;
      head1 = (q1.size() != 0) ? q1[0] : 32'h0;
      checkUnit("u0", q0.size(), 4, 2, 1'b1, head0, expOvf0, inReady0, outValid0,
                {outInstr0, outPc0}, {29'b0, count0}, stop0, ovfFlag0, push0, pop0, set0);
      checkUnit("u1", q1.size(), 8, 3, 1'b0, head1, expOvf1, inReady1, outValid1,
                {outInstr1, outPc1}, {28'b0, count1}, stop1, ovfFlag1, push1, pop1, set1);

      if (rst) begin
        q0.delete(); expOvf0 = 1'b0;
      end else if (flush) begin
        q0.delete();
      end else begin
        if (set0) expOvf0 = 1'b1;
        sz = q0.size();
        if (pop0 && sz != 0) void'(q0.pop_front());
        if (push0 && !(pop0 && sz == 0)) q0.push_back({inInstr, inPc});
      end

      if (rst) begin
        q1.delete(); expOvf1 = 1'b0;
      end else if (flush) begin
        q1.delete();
      end else begin
        if (set1) expOvf1 = 1'b1;
        sz = q1.size();
        if (pop1 && sz != 0) void'(q1.pop_front());
        if (push1 && !(pop1 && sz == 0)) q1.push_back({inInstr, inPc});
      end
      @(negedge clk);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
